// File: rtl/riscv_pkg.sv
// Shared RV32I controller definitions.
// Holds the base opcode enum, the multi-cycle FSM state enum and the
// encodings of the datapath select fields driven by the controllers.
package riscv_pkg;

    typedef enum logic [6:0] {
        OP_LOAD   = 7'b0000011,
        OP_STORE  = 7'b0100011,
        OP_R      = 7'b0110011,
        OP_I      = 7'b0010011,
        OP_BRANCH = 7'b1100011,
        OP_JAL    = 7'b1101111,
        OP_LUI    = 7'b0110111,
        OP_AUIPC  = 7'b0010111
    } opcode_e;

    typedef enum logic [3:0] {
        S_IDLE,
        S_FETCH,
        S_DECODE,
        S_MEM_ADR,
        S_MEM_READ,
        S_MEM_WB,
        S_MEM_WRITE,
        S_EXEC_R,
        S_EXEC_I,
        S_EXEC_LUI,
        S_EXEC_AUIPC,
        S_ALU_WB,
        S_BRANCH,
        S_JAL,
        S_TRAP
    } state_e;

    // ALU A operand select
    localparam logic [1:0] SRCA_PC    = 2'b00;
    localparam logic [1:0] SRCA_OLDPC = 2'b01;
    localparam logic [1:0] SRCA_RS1   = 2'b10;
    localparam logic [1:0] SRCA_ZERO  = 2'b11;

    // ALU B operand select
    localparam logic [1:0] SRCB_RS2   = 2'b00;
    localparam logic [1:0] SRCB_IMM   = 2'b01;
    localparam logic [1:0] SRCB_FOUR  = 2'b10;

    // Writeback / PC-next result select
    localparam logic [1:0] RES_ALUOUT = 2'b00;
    localparam logic [1:0] RES_MEM    = 2'b01;
    localparam logic [1:0] RES_ALU    = 2'b10;

    // ALU operation class
    localparam logic [1:0] ALUOP_ADD   = 2'b00;
    localparam logic [1:0] ALUOP_BR    = 2'b01;
    localparam logic [1:0] ALUOP_FUNCT = 2'b10;

    // Immediate format
    localparam logic [2:0] IMM_I = 3'b000;
    localparam logic [2:0] IMM_S = 3'b001;
    localparam logic [2:0] IMM_B = 3'b010;
    localparam logic [2:0] IMM_J = 3'b011;
    localparam logic [2:0] IMM_U = 3'b100;

endpackage

// File: rtl/imm_sel_decode.sv
// Immediate format decoder: op_code -> imm_src.
// Purely combinational; shared by the single- and multi-cycle builds.
// Ports:
//   op_code  in  7  opcode field of the instruction
//   imm_src  out 3  immediate format select (I/S/B/J/U)
module imm_sel_decode
    import riscv_pkg::*;
(
    input  logic [6:0] op_code,
    output logic [2:0] imm_src
);

    always_comb begin
        imm_src = IMM_I;
        case (op_code)
            OP_LOAD, OP_I:    imm_src = IMM_I;
            OP_STORE:         imm_src = IMM_S;
            OP_BRANCH:        imm_src = IMM_B;
            OP_JAL:           imm_src = IMM_J;
            OP_LUI, OP_AUIPC: imm_src = IMM_U;
            default:          imm_src = IMM_I;
        endcase
    end

endmodule

// File: rtl/multicycle_ctrl.sv
// Multi-cycle sequencing controller for the RV32I core.
// Walks one instruction at a time through fetch/decode/execute/memory/
// writeback and drives the shared single-ALU / single-memory datapath.
// Ports:
//   clk, rst_n        clock, async active-low reset
//   op_code, funct3   instruction register fields
//   mem_ready         memory port completes the access this cycle
//   take_branch       branch condition from the ALU (used in BRANCH)
//   mem_req/mem_write/mem_funct3/adr_src   unified memory port control
//   ir_write, pc_write                     IR/old-PC and PC enables
//   alu_src_a, alu_src_b, alu_op, imm_src  ALU operand / op selects
//   result_src, reg_write                  writeback select / enable
//   instr_done        one-cycle pulse on each instruction's last cycle
//   illegal_op        sticky unsupported-opcode flag (TRAP state)
module multicycle_ctrl
    import riscv_pkg::*;
#(
    parameter int unsigned RESET_PC_HOLD = 1
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic [6:0] op_code,
    input  logic [2:0] funct3,
    input  logic       mem_ready,
    input  logic       take_branch,
    output logic       mem_req,
    output logic       mem_write,
    output logic [2:0] mem_funct3,
    output logic       adr_src,
    output logic       ir_write,
    output logic       pc_write,
    output logic [1:0] alu_src_a,
    output logic [1:0] alu_src_b,
    output logic [1:0] alu_op,
    output logic [2:0] imm_src,
    output logic [1:0] result_src,
    output logic       reg_write,
    output logic       instr_done,
    output logic       illegal_op
);

    localparam logic [3:0] HOLD_LAST = 4'(RESET_PC_HOLD - 1);

    state_e     state, state_nxt;
    logic [3:0] hold_cnt;

    imm_sel_decode u_imm (
        .op_code (op_code),
        .imm_src (imm_src)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state    <= S_IDLE;
            hold_cnt <= '0;
        end else begin
            state <= state_nxt;
            // Only counts in IDLE; IDLE is never re-entered without reset.
            if (state == S_IDLE && hold_cnt != HOLD_LAST)
                hold_cnt <= hold_cnt + 4'd1;
        end
    end

    always_comb begin
        state_nxt = state;
        case (state)
            S_IDLE:      if (hold_cnt == HOLD_LAST) state_nxt = S_FETCH;
            S_FETCH:     if (mem_ready) state_nxt = S_DECODE;
            S_DECODE: begin
                case (op_code)
                    OP_LOAD, OP_STORE: state_nxt = S_MEM_ADR;
                    OP_R:              state_nxt = S_EXEC_R;
                    OP_I:              state_nxt = S_EXEC_I;
                    OP_BRANCH:         state_nxt = S_BRANCH;
                    OP_JAL:            state_nxt = S_JAL;
                    OP_LUI:            state_nxt = S_EXEC_LUI;
                    OP_AUIPC:          state_nxt = S_EXEC_AUIPC;
                    default:           state_nxt = S_TRAP;
                endcase
            end
            S_MEM_ADR:   state_nxt = (op_code == OP_STORE) ? S_MEM_WRITE : S_MEM_READ;
            S_MEM_READ:  if (mem_ready) state_nxt = S_MEM_WB;
            S_MEM_WB:    state_nxt = S_FETCH;
            S_MEM_WRITE: if (mem_ready) state_nxt = S_FETCH;
            S_EXEC_R, S_EXEC_I, S_EXEC_LUI, S_EXEC_AUIPC:
                         state_nxt = S_ALU_WB;
            S_ALU_WB:    state_nxt = S_FETCH;
            S_BRANCH:    state_nxt = S_FETCH;
            // JAL finishes through ALU_WB to write the link address PC+4.
            S_JAL:       state_nxt = S_ALU_WB;
            S_TRAP:      state_nxt = S_TRAP;
            default:     state_nxt = S_IDLE;
        endcase
    end

    // Moore outputs; ir_write, pc_write and instr_done are gated by inputs.
    always_comb begin
        mem_req    = 1'b0;
        mem_write  = 1'b0;
        mem_funct3 = 3'b000;
        adr_src    = 1'b0;
        ir_write   = 1'b0;
        pc_write   = 1'b0;
        alu_src_a  = SRCA_PC;
        alu_src_b  = SRCB_RS2;
        alu_op     = ALUOP_ADD;
        result_src = RES_ALUOUT;
        reg_write  = 1'b0;
        instr_done = 1'b0;
        illegal_op = 1'b0;
        case (state)
            S_FETCH: begin
                mem_req    = 1'b1;
                alu_src_a  = SRCA_PC;
                alu_src_b  = SRCB_FOUR;
                alu_op     = ALUOP_ADD;
                result_src = RES_ALU;
                ir_write   = mem_ready;
                pc_write   = mem_ready;
            end
            S_DECODE: begin
                // Precompute branch/JAL target into ALUOut.
                alu_src_a = SRCA_OLDPC;
                alu_src_b = SRCB_IMM;
            end
            S_MEM_ADR: begin
                alu_src_a = SRCA_RS1;
                alu_src_b = SRCB_IMM;
            end
            S_MEM_READ: begin
                mem_req    = 1'b1;
                adr_src    = 1'b1;
                mem_funct3 = funct3;
            end
            S_MEM_WB: begin
                result_src = RES_MEM;
                reg_write  = 1'b1;
                instr_done = 1'b1;
            end
            S_MEM_WRITE: begin
                mem_req    = 1'b1;
                mem_write  = 1'b1;
                adr_src    = 1'b1;
                mem_funct3 = funct3;
                instr_done = mem_ready;
            end
            S_EXEC_R: begin
                alu_src_a = SRCA_RS1;
                alu_src_b = SRCB_RS2;
                alu_op    = ALUOP_FUNCT;
            end
            S_EXEC_I: begin
                alu_src_a = SRCA_RS1;
                alu_src_b = SRCB_IMM;
                alu_op    = ALUOP_FUNCT;
            end
            S_EXEC_LUI: begin
                alu_src_a = SRCA_ZERO;
                alu_src_b = SRCB_IMM;
            end
            S_EXEC_AUIPC: begin
                alu_src_a = SRCA_OLDPC;
                alu_src_b = SRCB_IMM;
            end
            S_ALU_WB: begin
                result_src = RES_ALUOUT;
                reg_write  = 1'b1;
                instr_done = 1'b1;
            end
            S_BRANCH: begin
                alu_src_a  = SRCA_RS1;
                alu_src_b  = SRCB_RS2;
                alu_op     = ALUOP_BR;
                result_src = RES_ALUOUT;
                pc_write   = take_branch;
                instr_done = 1'b1;
            end
            S_JAL: begin
                alu_src_a  = SRCA_OLDPC;
                alu_src_b  = SRCB_FOUR;
                result_src = RES_ALUOUT;
                pc_write   = 1'b1;
            end
            S_TRAP:  illegal_op = 1'b1;
            default: ;
        endcase
    end

endmodule

// File: tb/tb_multicycle_ctrl.sv
// Self-checking bench for multicycle_ctrl (RESET_PC_HOLD = 2).
// A per-instruction model expands each instruction into its expected
// cycle-by-cycle output vectors; the bench drives and compares them.
module tb_multicycle_ctrl;

    localparam logic [6:0] LD = 7'b0000011, ST = 7'b0100011, RT = 7'b0110011,
                           IT = 7'b0010011, BR = 7'b1100011, JL = 7'b1101111,
                           LU = 7'b0110111, AU = 7'b0010111, BAD = 7'b1111111;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic [6:0] op_code = RT;
    logic [2:0] funct3 = 3'b000;
    logic       mem_ready = 1'b1;
    logic       take_branch = 1'b0;
    logic       mem_req, mem_write, adr_src, ir_write, pc_write;
    logic [2:0] mem_funct3, imm_src;
    logic [1:0] alu_src_a, alu_src_b, alu_op, result_src;
    logic       reg_write, instr_done, illegal_op;

    always #5 clk = ~clk;

    multicycle_ctrl #(.RESET_PC_HOLD(2)) dut (
        .clk(clk), .rst_n(rst_n), .op_code(op_code), .funct3(funct3),
        .mem_ready(mem_ready), .take_branch(take_branch),
        .mem_req(mem_req), .mem_write(mem_write), .mem_funct3(mem_funct3),
        .adr_src(adr_src), .ir_write(ir_write), .pc_write(pc_write),
        .alu_src_a(alu_src_a), .alu_src_b(alu_src_b), .alu_op(alu_op),
        .imm_src(imm_src), .result_src(result_src), .reg_write(reg_write),
        .instr_done(instr_done), .illegal_op(illegal_op)
    );

    wire [21:0] obs = {mem_req, mem_write, mem_funct3, adr_src, ir_write, pc_write,
                       alu_src_a, alu_src_b, alu_op, imm_src, result_src,
                       reg_write, instr_done, illegal_op};

    typedef struct { logic rdy; logic tk; logic [21:0] exp; } cyc_t;
    cyc_t q[$];
    int n_tests = 0;
    int n_fail  = 0;

    function automatic logic [2:0] imm_of(input logic [6:0] op);
        case (op)
            ST:      return 3'b001;
            BR:      return 3'b010;
            JL:      return 3'b011;
            LU, AU:  return 3'b100;
            default: return 3'b000;
        endcase
    endfunction

    function automatic logic [21:0] pack(input logic [6:0] op, input bit mreq, mwr,
        input logic [2:0] mf3, input bit adr, irw, pcw, input logic [1:0] a, b, aop,
        input logic [1:0] res, input bit rw, done, ill);
        return {mreq, mwr, mf3, adr, irw, pcw, a, b, aop, imm_of(op), res, rw, done, ill};
    endfunction

    function automatic void push(input bit rdy, tk, input logic [21:0] e);
        cyc_t c;
        c.rdy = rdy; c.tk = tk; c.exp = e;
        q.push_back(c);
    endfunction

    function automatic bit rb();
        return 1'($urandom_range(0, 1));
    endfunction

    // Expected cycles of one instruction; mem_ready/take_branch are random
    // wherever the controller must ignore them.
    function automatic void expand(input logic [6:0] op, input logic [2:0] f3,
                                   input int wf, input int wm, input bit tk);
        for (int i = 0; i < wf; i++)
            push(0, rb(), pack(op, 1,0,3'b0,0,0,0, 2'b00,2'b10,2'b00, 2'b10, 0,0,0));
        push(1, rb(), pack(op, 1,0,3'b0,0,1,1, 2'b00,2'b10,2'b00, 2'b10, 0,0,0));
        push(rb(), rb(), pack(op, 0,0,3'b0,0,0,0, 2'b01,2'b01,2'b00, 2'b00, 0,0,0));
        case (op)
            LD: begin
                push(rb(), rb(), pack(op, 0,0,3'b0,0,0,0, 2'b10,2'b01,2'b00, 2'b00, 0,0,0));
                for (int i = 0; i < wm; i++)
                    push(0, rb(), pack(op, 1,0,f3,1,0,0, 2'b00,2'b00,2'b00, 2'b00, 0,0,0));
                push(1, rb(), pack(op, 1,0,f3,1,0,0, 2'b00,2'b00,2'b00, 2'b00, 0,0,0));
                push(rb(), rb(), pack(op, 0,0,3'b0,0,0,0, 2'b00,2'b00,2'b00, 2'b01, 1,1,0));
            end
            ST: begin
                push(rb(), rb(), pack(op, 0,0,3'b0,0,0,0, 2'b10,2'b01,2'b00, 2'b00, 0,0,0));
                for (int i = 0; i < wm; i++)
                    push(0, rb(), pack(op, 1,1,f3,1,0,0, 2'b00,2'b00,2'b00, 2'b00, 0,0,0));
                push(1, rb(), pack(op, 1,1,f3,1,0,0, 2'b00,2'b00,2'b00, 2'b00, 0,1,0));
            end
            BR: push(rb(), tk, pack(op, 0,0,3'b0,0,0,tk, 2'b10,2'b00,2'b01, 2'b00, 0,1,0));
            RT, IT, LU, AU, JL: begin
                case (op)
                    RT: push(rb(), rb(), pack(op, 0,0,3'b0,0,0,0, 2'b10,2'b00,2'b10, 2'b00, 0,0,0));
                    IT: push(rb(), rb(), pack(op, 0,0,3'b0,0,0,0, 2'b10,2'b01,2'b10, 2'b00, 0,0,0));
                    LU: push(rb(), rb(), pack(op, 0,0,3'b0,0,0,0, 2'b11,2'b01,2'b00, 2'b00, 0,0,0));
                    AU: push(rb(), rb(), pack(op, 0,0,3'b0,0,0,0, 2'b01,2'b01,2'b00, 2'b00, 0,0,0));
                    default: push(rb(), rb(), pack(op, 0,0,3'b0,0,0,1, 2'b01,2'b10,2'b00, 2'b00, 0,0,0));
                endcase
                push(rb(), rb(), pack(op, 0,0,3'b0,0,0,0, 2'b00,2'b00,2'b00, 2'b00, 1,1,0));
            end
            default: ; // illegal: caller appends TRAP cycles
        endcase
    endfunction

    task automatic check(input string name, input int k, input logic [21:0] got, exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s cyc %0d got %h exp %h", name, k, got, exp);
        end
    endtask

    task automatic check_int(input string name, input int got, exp);
        n_tests++;
        if (got != exp) begin
            n_fail++;
            $display("FAIL %s got %0d exp %0d", name, got, exp);
        end
    endtask

    // Called just after a rising edge; samples each cycle on the falling edge.
    task automatic run(input string name, input int limit, output int ndone, output int done_at);
        int k;
        k = 0; ndone = 0; done_at = -1;
        while (q.size() > 0 && k < limit) begin
            cyc_t c;
            c = q.pop_front();
            mem_ready = c.rdy;
            take_branch = c.tk;
            @(negedge clk);
            check(name, k, obs, c.exp);
            if (instr_done) begin ndone++; done_at = k + 1; end
            @(posedge clk); #1;
            k++;
        end
    endtask

    task automatic idle2(input string name);
        int nd, da;
        push(1, 0, pack(op_code, 0,0,3'b0,0,0,0, 2'b00,2'b00,2'b00, 2'b00, 0,0,0));
        push(1, 0, pack(op_code, 0,0,3'b0,0,0,0, 2'b00,2'b00,2'b00, 2'b00, 0,0,0));
        run(name, 1000, nd, da);
        check_int({name, "_done"}, nd, 0);
    endtask

    typedef struct { logic [6:0] op; logic [2:0] f3; int wf; int wm; bit tk; int cpi; string name; } vec_t;
    vec_t tbl[11];
    logic [6:0] legal[8];

    initial begin
        int nd, da;
        tbl[0]  = '{LD, 3'b010, 0, 2, 1'b0, 7, "load_wait2"};
        tbl[1]  = '{BR, 3'b000, 0, 0, 1'b1, 3, "branch_taken"};
        tbl[2]  = '{BR, 3'b000, 0, 0, 1'b0, 3, "branch_not"};
        tbl[3]  = '{ST, 3'b000, 0, 0, 1'b0, 4, "store"};
        tbl[4]  = '{RT, 3'b000, 0, 0, 1'b0, 4, "rtype"};
        tbl[5]  = '{JL, 3'b000, 0, 0, 1'b0, 4, "jal"};
        tbl[6]  = '{LU, 3'b000, 0, 0, 1'b0, 4, "lui"};
        tbl[7]  = '{IT, 3'b101, 1, 0, 1'b0, 5, "itype_fw1"};
        tbl[8]  = '{AU, 3'b000, 2, 0, 1'b0, 6, "auipc_fw2"};
        tbl[9]  = '{ST, 3'b001, 1, 1, 1'b0, 6, "store_w"};
        tbl[10] = '{LD, 3'b100, 0, 0, 1'b0, 5, "load"};
        legal = '{LD, ST, RT, IT, BR, JL, LU, AU};

        // Reset state
        @(posedge clk); #1;
        @(negedge clk);
        check("reset", 0, obs, pack(op_code, 0,0,3'b0,0,0,0, 2'b00,2'b00,2'b00, 2'b00, 0,0,0));
        @(posedge clk); #1;
        rst_n = 1'b1;
        idle2("idle_hold");

        // Directed table
        foreach (tbl[i]) begin
            op_code = tbl[i].op;
            funct3  = tbl[i].f3;
            expand(tbl[i].op, tbl[i].f3, tbl[i].wf, tbl[i].wm, tbl[i].tk);
            run(tbl[i].name, 1000, nd, da);
            check_int({tbl[i].name, "_ndone"}, nd, 1);
            check_int({tbl[i].name, "_cpi"}, da, tbl[i].cpi);
        end

        // Randomized instruction stream against the model
        for (int n = 0; n < 60; n++) begin
            logic [6:0] op;
            logic [2:0] f3;
            op = legal[$urandom_range(0, 7)];
            f3 = 3'($urandom_range(0, 7));
            op_code = op;
            funct3  = f3;
            expand(op, f3, $urandom_range(0, 3), $urandom_range(0, 3), rb());
            run("rand", 1000, nd, da);
            check_int("rand_ndone", nd, 1);
        end

        // Reset in the middle of a stalled load read
        op_code = LD; funct3 = 3'b100;
        expand(LD, 3'b100, 0, 5, 1'b0);
        run("midrst", 3, nd, da);
        mem_ready = 1'b0;
        @(negedge clk);
        check("midrst_read", 3, obs, q[0].exp);
        q.delete();
        #2 rst_n = 1'b0;
        #1 check("midrst_drop", 0, obs, pack(LD, 0,0,3'b0,0,0,0, 2'b00,2'b00,2'b00, 2'b00, 0,0,0));
        @(posedge clk); #1;
        rst_n = 1'b1;
        idle2("midrst_idle");

        // Illegal opcode -> TRAP, sticky until reset
        op_code = BAD; funct3 = 3'b000;
        expand(BAD, 3'b000, 0, 0, 1'b0);
        for (int i = 0; i < 10; i++)
            push(rb(), rb(), pack(BAD, 0,0,3'b0,0,0,0, 2'b00,2'b00,2'b00, 2'b00, 0,0,1));
        run("trap", 1000, nd, da);
        check_int("trap_ndone", nd, 0);
        rst_n = 1'b0;
        #1 check("trap_rst", 0, obs, pack(BAD, 0,0,3'b0,0,0,0, 2'b00,2'b00,2'b00, 2'b00, 0,0,0));
        #2 rst_n = 1'b1;
        op_code = RT;
        idle2("trap_idle");
        expand(RT, 3'b000, 0, 0, 1'b0);
        run("after_trap", 1000, nd, da);
        check_int("after_trap_cpi", da, 4);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
